// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg
//   Shared definitions for the SDRAM fill bridge: FSM state encoding,
//   burst length and buffer index width.
//   No ports (package).
package sdram_bridge_pkg;

  // Words per read burst; the bridge is built around a 4-word line fill.
  localparam int BURST_LEN_C = 4;
  localparam int IDX_W       = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISSUE  = 3'd1,
    S_COLLECT = 3'd2,
    S_REPLAY  = 3'd3,
    S_WISSUE  = 3'd4,
    S_WDONE   = 3'd5
  } state_t;

endpackage

// File: rtl/burst_buffer.sv
// burst_buffer
//   4 x 16-bit register file holding one read burst while it is collected
//   from the SDRAM controller, then replayed to the cache.
// Ports:
//   clk       in  clock (rising edge)
//   i_we      in  write enable
//   i_idx     in  write index
//   i_data    in  write data
//   i_rd_idx  in  read index (combinational read)
//   o_rd_data out read data
// Contents are not reset; they are always written before being read.
module burst_buffer
  import sdram_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [15:0]      i_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [15:0]      o_rd_data
);

  logic [15:0] r_mem [BURST_LEN_C];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/sdram_fill_bridge.sv
// sdram_fill_bridge
//   Bridges a cache miss/write port to an SDRAM controller. Reads fetch an
//   aligned 4-word burst (words may arrive with gaps), then replay it to the
//   cache on 4 consecutive cycles with cache_fill marking word 0. Writes are
//   single-word with byte enables and complete with a cache_wack strobe.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   cache_*           cache side: addr/req/rw/wdata/wbe in, fill/rdata/wack out
//   mem_*             controller side: req/rw/addr/wdata/wbe out, ack/rvalid/rdata in
//   busy              high whenever the FSM is not in IDLE
//   dbg_state         current FSM state, for observation only
// Handshake: mem_req is held with stable mem_addr/mem_rw/mem_wdata/mem_wbe
//   until mem_ack is sampled high; mem_req is low from the next cycle on.
//   The cache holds cache_req high until served (fill or wack).
// All outputs are registered.
module sdram_fill_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_C,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_req,
  input  logic              cache_rw,
  input  logic [15:0]       cache_wdata,
  input  logic [1:0]        cache_wbe,
  output logic              cache_fill,
  output logic [15:0]       cache_rdata,
  output logic              cache_wack,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_wbe,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_cnt;
  logic                r_need_low;
  logic                r_mem_req;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic [1:0]          r_mem_wbe;
  logic                r_fill;
  logic                r_wack;
  logic [15:0]         r_rdata;
  logic                r_busy;

  logic                w_buf_we;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [15:0]         w_rd_data;

  // Only COLLECT stores words; stray rvalids elsewhere are dropped.
  assign w_buf_we = reset && (r_state == S_COLLECT) && mem_rvalid;
  // Outside REPLAY index 0 is presented so word 0 is ready the moment the
  // last word lands, giving a 1-cycle fill latency.
  assign w_rd_idx = (r_state == S_REPLAY) ? r_cnt : '0;

  burst_buffer u_buf (
    .clk       (clk),
    .i_we      (w_buf_we),
    .i_idx     (r_cnt),
    .i_data    (mem_rdata),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_need_low  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_rw    <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wbe   <= '0;
      r_fill      <= 1'b0;
      r_wack      <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_fill <= 1'b0;
      r_wack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // After a fill the cache's request is still high for a cycle;
          // wait until it is seen low so the same miss is not re-issued.
          if (r_need_low) begin
            if (!cache_req) r_need_low <= 1'b0;
          end else if (cache_req) begin
            r_mem_addr  <= cache_rw ? {cache_addr[ADDR_W-1:3], 3'b000} : cache_addr;
            r_mem_wdata <= cache_wdata;
            r_mem_wbe   <= cache_wbe;
            r_mem_rw    <= cache_rw;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= cache_rw ? S_RISSUE : S_WISSUE;
          end
        end
        S_RISSUE: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (mem_rvalid) begin
            if (r_cnt == LAST_IDX) begin
              // Last word: start the replay with word 0 right away.
              r_fill  <= 1'b1;
              r_rdata <= w_rd_data;
              r_cnt   <= IDX_W'(1);
              r_state <= S_REPLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_REPLAY: begin
          r_rdata <= w_rd_data;
          if (r_cnt == LAST_IDX) begin
            r_cnt      <= '0;
            r_need_low <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WISSUE: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_wack    <= 1'b1;
            r_state   <= S_WDONE;
          end
        end
        S_WDONE: begin
          if (!cache_req) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign cache_fill  = r_fill;
  assign cache_rdata = r_rdata;
  assign cache_wack  = r_wack;
  assign mem_req     = r_mem_req;
  assign mem_rw      = r_mem_rw;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wbe     = r_mem_wbe;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sdram_fill_bridge.sv
// tb_sdram_fill_bridge
//   Directed bench for sdram_fill_bridge. Inputs change 1 time unit after
//   the rising edge and outputs are checked at that same point.
module tb_sdram_fill_bridge;
  import sdram_bridge_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] cache_addr;
  logic        cache_req;
  logic        cache_rw;
  logic [15:0] cache_wdata;
  logic [1:0]  cache_wbe;
  logic        cache_fill;
  logic [15:0] cache_rdata;
  logic        cache_wack;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wbe;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  sdram_fill_bridge #(.BURST_LEN(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cache_addr  (cache_addr),
    .cache_req   (cache_req),
    .cache_rw    (cache_rw),
    .cache_wdata (cache_wdata),
    .cache_wbe   (cache_wbe),
    .cache_fill  (cache_fill),
    .cache_rdata (cache_rdata),
    .cache_wack  (cache_wack),
    .mem_req     (mem_req),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wbe     (mem_wbe),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full read: request, ack after ack_dly wait cycles, words with the
  // given gaps before words 1..3, then replay checks against exp_q.
  task automatic do_read(input logic [31:0] addr,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3,
                         input int g1, input int g2, input int g3,
                         input int ack_dly, input bit keep_req);
    logic [15:0] words [4];
    int          gaps  [4];
    logic [15:0] exp_w;
    logic [31:0] aligned;
    words   = '{w0, w1, w2, w3};
    gaps    = '{0, g1, g2, g3};
    aligned = {addr[31:3], 3'b000};
    for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);

    cache_req  = 1'b1;
    cache_rw   = 1'b1;
    cache_addr = addr;
    tick();
    cache_addr = ~addr;              // must not disturb the latched request
    chk("rd_req", {31'd0, mem_req}, 32'd1);
    chk("rd_addr", mem_addr, aligned);
    chk("rd_rw", {31'd0, mem_rw}, 32'd1);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("rd_req_hold", {31'd0, mem_req}, 32'd1);
      chk("rd_addr_hold", mem_addr, aligned);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rd_req_drop", {31'd0, mem_req}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        chk("rd_gap_fill", {31'd0, cache_fill}, 32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = words[i];
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 16'(~words[i]);
      if (i < 3) chk("rd_early_fill", {31'd0, cache_fill}, 32'd0);
    end

    for (int k = 0; k < 4; k++) begin
      exp_w = exp_q.pop_front();
      chk("fill_strobe", {31'd0, cache_fill}, (k == 0) ? 32'd1 : 32'd0);
      chk("fill_data", {16'd0, cache_rdata}, {16'd0, exp_w});
      if (k == 0 && !keep_req) cache_req = 1'b0;
      if (k < 3) tick();
    end
    tick();
    chk("post_fill", {31'd0, cache_fill}, 32'd0);
    chk("post_hold", {16'd0, cache_rdata}, {16'd0, w3});
    chk("post_noreissue", {31'd0, mem_req}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    if (keep_req) begin
      cache_req = 1'b0;
      tick();
      chk("post_noreissue2", {31'd0, mem_req}, 32'd0);
    end
  endtask

  initial begin
    reset       = 1'b0;
    cache_addr  = 32'h0;
    cache_req   = 1'b0;
    cache_rw    = 1'b1;
    cache_wdata = 16'h0;
    cache_wbe   = 2'b00;
    mem_ack     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 16'h0;

    // reset state
    tick();
    tick();
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_fill", {31'd0, cache_fill}, 32'd0);
    chk("rst_wack", {31'd0, cache_wack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_wbe", {30'd0, mem_wbe}, 32'd0);
    chk("rst_rdata", {16'd0, cache_rdata}, 32'd0);
    reset = 1'b1;
    tick();

    // basic read, immediate ack, back-to-back words
    do_read(32'h1234, 16'hA0, 16'hA1, 16'hA2, 16'hA3, 0, 0, 0, 0, 1'b0);

    // read with gaps between words, delayed ack, cache_req held past the fill
    do_read(32'h0000_5678, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 2, 5, 2, 1'b1);

    // write with delayed ack
    cache_req   = 1'b1;
    cache_rw    = 1'b0;
    cache_addr  = 32'h100;
    cache_wdata = 16'hBEEF;
    cache_wbe   = 2'b10;
    tick();
    cache_addr  = 32'hFFFF_FFFF;
    cache_wdata = 16'h0000;
    cache_wbe   = 2'b01;
    chk("wr_req", {31'd0, mem_req}, 32'd1);
    chk("wr_rw", {31'd0, mem_rw}, 32'd0);
    chk("wr_addr", mem_addr, 32'h100);
    chk("wr_data", {16'd0, mem_wdata}, 32'h0000_BEEF);
    chk("wr_wbe", {30'd0, mem_wbe}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_req_hold", {31'd0, mem_req}, 32'd1);
      chk("wr_data_hold", {16'd0, mem_wdata}, 32'h0000_BEEF);
      chk("wr_wbe_hold", {30'd0, mem_wbe}, 32'd2);
      chk("wr_wack_early", {31'd0, cache_wack}, 32'd0);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr_req_drop", {31'd0, mem_req}, 32'd0);
    chk("wr_wack", {31'd0, cache_wack}, 32'd1);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_wack_once", {31'd0, cache_wack}, 32'd0);
      chk("wr_noreissue", {31'd0, mem_req}, 32'd0);
      chk("wr_wdone_busy", {31'd0, busy}, 32'd1);
    end
    cache_req = 1'b0;
    tick();
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    chk("wr_idle_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // stray rvalid / ack while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    mem_ack    = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b0;
    mem_ack    = 1'b0;
    chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
    chk("stray_fill", {31'd0, cache_fill}, 32'd0);
    do_read(32'h0000_0A0C, 16'hC0DE, 16'hC1DE, 16'hC2DE, 16'hC3DE, 1, 0, 3, 1, 1'b0);

    // reset after two of four words
    cache_req  = 1'b1;
    cache_rw   = 1'b1;
    cache_addr = 32'h2000;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h7700 + 16'(i);
      tick();
    end
    mem_rvalid = 1'b0;
    reset      = 1'b0;
    tick();
    chk("abort_fill", {31'd0, cache_fill}, 32'd0);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_rw", {31'd0, mem_rw}, 32'd1);
    chk("abort_addr", mem_addr, 32'd0);
    reset     = 1'b1;
    cache_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h7800 + 16'(i);
      tick();
      chk("abort_nofill", {31'd0, cache_fill}, 32'd0);
    end
    mem_rvalid = 1'b0;
    tick();
    do_read(32'h2008, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 0, 0, 0, 0, 1'b0);

    // back-to-back reads, request re-asserted one cycle after the replay
    do_read(32'h0000_3001, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 1'b0);
    do_read(32'h0000_300F, 16'h1357, 16'h2468, 16'h9BDF, 16'hACE0, 0, 0, 0, 1, 1'b0);

    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_fill_bridge.md
SDRAM_FILL_BRIDGE -- requirements
Module: sdram_fill_bridge

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, words per read burst; only 4 is supported.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the address ports.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port cache_addr  in  ADDR_W  byte address from the cache.
REQ-006 SHALL have port cache_req  in  1  request; held high until served.
REQ-007 SHALL have port cache_rw  in  1  1 = burst read, 0 = single-word write.
REQ-008 SHALL have port cache_wdata  in  16  write data.
REQ-009 SHALL have port cache_wbe  in  2  write byte enables, bit1 = upper byte.
REQ-010 SHALL have port cache_fill  out  1  one-cycle strobe marking burst word 0.
REQ-011 SHALL have port cache_rdata  out  16  fill data.
REQ-012 SHALL have port cache_wack  out  1  one-cycle write-complete strobe.
REQ-013 SHALL have port mem_req  out  1  request to the SDRAM controller.
REQ-014 SHALL have port mem_rw  out  1  1 = read, 0 = write.
REQ-015 SHALL have port mem_addr  out  ADDR_W  controller address.
REQ-016 SHALL have port mem_wdata  out  16  controller write data.
REQ-017 SHALL have port mem_wbe  out  2  controller byte enables.
REQ-018 SHALL have port mem_ack  in  1  controller accepted the request.
REQ-019 SHALL have port mem_rvalid  in  1  controller read word valid; gaps allowed.
REQ-020 SHALL have port mem_rdata  in  16  controller read word.
REQ-021 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-022 SHALL implement states IDLE, RISSUE, COLLECT, REPLAY, WISSUE, WDONE.
REQ-023 IDLE with cache_req=1: SHALL latch the address, forcing bits [2:0] to 0 for reads and keeping the address unchanged for writes, latch wdata and wbe, then go to RISSUE (rw=1) or WISSUE (rw=0).
REQ-024 RISSUE/WISSUE: SHALL hold mem_req=1 with a stable mem_addr, mem_rw, mem_wdata and mem_wbe until mem_ack=1 is sampled; mem_req SHALL drop in the following cycle.
REQ-025 After a read ack: SHALL go to COLLECT with word counter = 0.
REQ-026 COLLECT: each mem_rvalid=1 SHALL store mem_rdata at buffer[counter] and increment the counter; the 4th word SHALL move the block to REPLAY.
REQ-027 REPLAY: SHALL drive buffer[0..3] on cache_rdata in 4 consecutive cycles, with cache_fill=1 only in the buffer[0] cycle, then go to IDLE.
REQ-028 Minimum fill latency SHALL be 1 cycle after the 4th mem_rvalid.
REQ-029 After a write ack: SHALL go to WDONE, pulse cache_wack for 1 cycle, and stay in WDONE until cache_req=0, then go to IDLE.
REQ-030 IDLE SHALL NOT accept a new request in the cycle it is entered from REPLAY; it SHALL first sample cache_req=0, which suppresses re-issue.
REQ-031 mem_rvalid outside COLLECT SHALL be ignored.
REQ-032 mem_ack outside RISSUE/WISSUE SHALL be ignored.
REQ-033 Words SHALL be returned in linear order, offset 0..3 from the aligned address.
REQ-034 cache_rdata outside REPLAY SHALL hold its last value; cache_fill and cache_wack SHALL be 0.
REQ-035 Changes on cache_addr, cache_wdata or cache_wbe after the request is latched SHALL NOT affect the transfer in progress.

Reset
REQ-036 With reset=0 at a clock edge: state SHALL become IDLE, and mem_req, cache_fill, cache_wack and busy SHALL be 0 on the next cycle.
REQ-037 Reset SHALL set the counter to 0, and mem_addr, mem_wdata, mem_wbe and cache_rdata to 0; mem_rw SHALL reset to 1.
REQ-038 Reset mid-COLLECT or mid-REPLAY SHALL abort with no further cache_fill; the buffer contents are don't-care.

Structure
REQ-039 A shared package sdram_bridge_pkg SHALL hold the state encoding and the BURST_LEN constant.
REQ-040 The 4x16 register buffer SHALL be a sub-module burst_buffer with write port (we, idx, data) and read index.
REQ-041 All outputs SHALL be registered.

Verification
REQ-042 Read at 0x1234 with immediate ack and rvalid on 4 consecutive cycles, data A0,A1,A2,A3 -> mem_addr=0x1230; cache_fill one cycle, data A0 then A1,A2,A3 on the next 3 cycles.
REQ-043 Read with rvalid gaps of 0,2,5 cycles between words -> same 4-word consecutive replay; fill 1 cycle after the 4th rvalid.
REQ-044 Write 0xBEEF at 0x100, wbe=2'b10, mem_ack delayed 3 cycles -> mem_req held 4 cycles, mem_wbe=2'b10; cache_wack 1 cycle later; no re-issue while cache_req stays high.
REQ-045 Stray mem_rvalid in IDLE, then a normal read -> the stray word is not in the replay.
REQ-046 reset=0 after 2 of 4 rvalids -> no cache_fill; the next read completes correctly.
REQ-047 Back-to-back reads with cache_req re-asserted 1 cycle after REPLAY -> second burst issued; both fills correct.
